psum_id_config_loader: RTL and testbench

PSUM_ID_CONFIG_LOADER -- requirements
Module: psum_id_config_loader

---
 rtl/psum_id_config_loader.sv | 175 +++++++++++++++++
 tb/tb_psum_id_config_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_id_config_loader.sv
// ---------------------------------------------------------------------------
// psum_id_config_loader
//
// Purpose:
//   Loads one layer's partial-sum routing configuration from a narrow beat
//   stream and publishes it to the psum selection decoder. One load is a
//   layer RS beat, then one row-ID beat per PE row, then one col-ID beat per
//   PE (row-major). Beats go into shadow registers. The committed outputs
//   change only in the single COMMIT cycle that ends a load, so the decoder
//   never sees a half-written configuration.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        one-cycle request to begin a load (honoured only in IDLE)
//   i_cfg_valid    config beat valid
//   i_cfg_data     config beat payload; IDs are taken from the LSBs
//   o_cfg_ready    loader accepts a beat this cycle
//   o_layer_RS     committed layer RS value
//   o_psum_row_id  committed row IDs, row 0 in the most significant slot
//   o_psum_col_id  committed col IDs, row-major, PE(0,0) most significant
//   o_busy         load in progress
//   o_cfg_valid    committed outputs hold a complete configuration
//   o_cfg_done     one-cycle pulse while the commit happens
// ---------------------------------------------------------------------------
module psum_id_config_loader #(
    parameter int NUM_ROWS             = 3,
    parameter int NUM_COLS             = 3,
    parameter int PSUM_ROW_ID_BITWIDTH = 4,
    parameter int PSUM_COL_ID_BITWIDTH = 4,
    parameter int CFG_DATA_WIDTH       = 4
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst_n,
    input  logic                                              i_start,
    input  logic                                              i_cfg_valid,
    input  logic [CFG_DATA_WIDTH-1:0]                         i_cfg_data,
    output logic                                              o_cfg_ready,
    output logic [3:0]                                        o_layer_RS,
    output logic [NUM_ROWS*PSUM_ROW_ID_BITWIDTH-1:0]          o_psum_row_id,
    output logic [NUM_ROWS*NUM_COLS*PSUM_COL_ID_BITWIDTH-1:0] o_psum_col_id,
    output logic                                              o_busy,
    output logic                                              o_cfg_valid,
    output logic                                              o_cfg_done
);

    localparam int RW      = PSUM_ROW_ID_BITWIDTH;
    localparam int CW      = PSUM_COL_ID_BITWIDTH;
    localparam int NUM_PES = NUM_ROWS * NUM_COLS;
    // The counter only has to reach the largest in-state index (NUM_PES-1).
    localparam int CNT_W   = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_RS  = 3'd1;
    localparam logic [2:0] S_LOAD_ROW = 3'd2;
    localparam logic [2:0] S_LOAD_COL = 3'd3;
    localparam logic [2:0] S_COMMIT   = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_nextState;
    logic [CNT_W-1:0]       r_beatCnt;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_lastRow;
    logic                   w_lastCol;

    logic [3:0]             r_shadowRs;
    logic [RW-1:0]          r_shadowRow [NUM_ROWS];
    logic [CW-1:0]          r_shadowCol [NUM_PES];
    logic [NUM_ROWS*RW-1:0] w_shadowRowFlat;
    logic [NUM_PES*CW-1:0]  w_shadowColFlat;

    logic [3:0]             r_layerRs;
    logic [NUM_ROWS*RW-1:0] r_rowId;
    logic [NUM_PES*CW-1:0]  r_colId;
    logic                   r_cfgValid;

    assign w_ready   = (r_state == S_LOAD_RS) || (r_state == S_LOAD_ROW) ||
                       (r_state == S_LOAD_COL);
    assign w_accept  = i_cfg_valid && w_ready;
    assign w_lastRow = (r_beatCnt == CNT_W'(NUM_ROWS - 1));
    assign w_lastCol = (r_beatCnt == CNT_W'(NUM_PES - 1));

    // Next-state logic. i_start is only looked at in IDLE. A load in
    // progress cannot be restarted.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_nextState = S_LOAD_RS;
            S_LOAD_RS:  if (w_accept) w_nextState = S_LOAD_ROW;
            S_LOAD_ROW: if (w_accept && w_lastRow) w_nextState = S_LOAD_COL;
            S_LOAD_COL: if (w_accept && w_lastCol) w_nextState = S_COMMIT;
            S_COMMIT:   w_nextState = S_IDLE;
            default:    w_nextState = S_IDLE;
        endcase
    end

    // The state register and beat counter. The counter clears whenever the
    // state changes, so each state indexes its slots from 0. The last beat of
    // a state always leaves that state, so the counter cannot wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_beatCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState != r_state)
                r_beatCnt <= '0;
            else if (w_accept)
                r_beatCnt <= r_beatCnt + 1'b1;
        end
    end

    // The shadow registers. Only accepted beats write them. Payload bits
    // above the destination width are dropped here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadowRs <= '0;
            for (int k = 0; k < NUM_ROWS; k++) r_shadowRow[k] <= '0;
            for (int k = 0; k < NUM_PES; k++)  r_shadowCol[k] <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_LOAD_RS: r_shadowRs <= i_cfg_data[3:0];
                S_LOAD_ROW: begin
                    for (int k = 0; k < NUM_ROWS; k++)
                        if (r_beatCnt == CNT_W'(k))
                            r_shadowRow[k] <= i_cfg_data[RW-1:0];
                end
                S_LOAD_COL: begin
                    for (int k = 0; k < NUM_PES; k++)
                        if (r_beatCnt == CNT_W'(k))
                            r_shadowCol[k] <= i_cfg_data[CW-1:0];
                end
                default: ;
            endcase
        end
    end

    // Pack the shadow slots into the output ordering: slot 0 goes in the
    // most significant position.
    always_comb begin
        w_shadowRowFlat = '0;
        w_shadowColFlat = '0;
        for (int k = 0; k < NUM_ROWS; k++)
            w_shadowRowFlat[(NUM_ROWS-1-k)*RW +: RW] = r_shadowRow[k];
        for (int k = 0; k < NUM_PES; k++)
            w_shadowColFlat[(NUM_PES-1-k)*CW +: CW] = r_shadowCol[k];
    end

    // The committed configuration. It is copied from the shadows on the edge
    // that leaves COMMIT, and it is not touched at any other time. Once
    // o_cfg_valid is set, it stays set through later reloads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_layerRs  <= '0;
            r_rowId    <= '0;
            r_colId    <= '0;
            r_cfgValid <= 1'b0;
        end else if (r_state == S_COMMIT) begin
            r_layerRs  <= r_shadowRs;
            r_rowId    <= w_shadowRowFlat;
            r_colId    <= w_shadowColFlat;
            r_cfgValid <= 1'b1;
        end
    end

    assign o_cfg_ready   = w_ready;
    assign o_busy        = (r_state != S_IDLE);
    assign o_cfg_done    = (r_state == S_COMMIT);
    assign o_cfg_valid   = r_cfgValid;
    assign o_layer_RS    = r_layerRs;
    assign o_psum_row_id = r_rowId;
    assign o_psum_col_id = r_colId;

endmodule

// File: tb/tb_psum_id_config_loader.sv
// ---------------------------------------------------------------------------
// tb_psum_id_config_loader
//
// Purpose:
//   Self-checking bench for psum_id_config_loader. A default-sized instance
//   is the main DUT. A second instance with 2-bit row IDs shares its inputs,
//   so row-ID truncation is exercised on every load. Each table entry is one
//   full load. Its expected commit is queued when the load starts and is
//   checked when the DUT pulses o_cfg_done. Reset behaviour and an aborted
//   load are written out by hand.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_psum_id_config_loader;

    localparam int NR    = 3;
    localparam int NC    = 3;
    localparam int BEATS = 1 + NR + NR * NC;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic        i_cfg_valid;
    logic [3:0]  i_cfg_data;

    logic        o_cfg_ready, o_busy, o_cfg_valid, o_cfg_done;
    logic [3:0]  o_layer_RS;
    logic [11:0] o_psum_row_id;
    logic [35:0] o_psum_col_id;

    logic        b_cfg_ready, b_busy, b_cfg_valid, b_cfg_done;
    logic [3:0]  b_layer_RS;
    logic [5:0]  b_psum_row_id;
    logic [35:0] b_psum_col_id;

    psum_id_config_loader dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_cfg_valid(i_cfg_valid), .i_cfg_data(i_cfg_data),
        .o_cfg_ready(o_cfg_ready), .o_layer_RS(o_layer_RS),
        .o_psum_row_id(o_psum_row_id), .o_psum_col_id(o_psum_col_id),
        .o_busy(o_busy), .o_cfg_valid(o_cfg_valid), .o_cfg_done(o_cfg_done)
    );

    psum_id_config_loader #(.PSUM_ROW_ID_BITWIDTH(2)) dutNarrow (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_cfg_valid(i_cfg_valid), .i_cfg_data(i_cfg_data),
        .o_cfg_ready(b_cfg_ready), .o_layer_RS(b_layer_RS),
        .o_psum_row_id(b_psum_row_id), .o_psum_col_id(b_psum_col_id),
        .o_busy(b_busy), .o_cfg_valid(b_cfg_valid), .o_cfg_done(b_cfg_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4*BEATS-1:0] beats;
        bit                 bubbles;
        bit                 startMid;
        logic [3:0]         expRs;
        logic [11:0]        expRow;
        logic [35:0]        expCol;
        logic [5:0]         expRow2;
    } vec_t;

    typedef struct {
        logic [3:0]  rs;
        logic [11:0] row;
        logic [35:0] col;
        logic [5:0]  row2;
    } exp_t;

    vec_t  vecs [5];
    exp_t  sbQueue [$];
    exp_t  lastCommit;
    bit    lastValid;
    bit    armed = 1'b0;
    int    testsRun = 0;
    int    testsFailed = 0;

    // Compares one value and reports a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one beat and waits (bounded) until it is accepted. With
    // bubble set, a cycle with valid low and scrambled data follows.
    task automatic sendBeat(input logic [3:0] d, input bit bubble, output bit ok);
        int waitCnt;
        waitCnt = 0;
        i_cfg_valid = 1'b1;
        i_cfg_data  = d;
        while (!o_cfg_ready && waitCnt < 50) begin
            @(negedge i_clk);
            waitCnt++;
        end
        ok = o_cfg_ready;
        @(negedge i_clk);
        if (bubble) begin
            i_cfg_valid = 1'b0;
            i_cfg_data  = ~d;
            @(negedge i_clk);
        end
    endtask

    // Runs one full load from a table entry and queues its expected commit.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        bit   ok;
        int   accepted;
        accepted = 0;
        e.rs = v.expRs; e.row = v.expRow; e.col = v.expCol; e.row2 = v.expRow2;
        sbQueue.push_back(e);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        checkOutput("busyAfterStart", 64'(o_busy), 64'd1);
        checkOutput("readyAfterStart", 64'(o_cfg_ready), 64'd1);
        for (int k = 0; k < BEATS; k++) begin
            if (v.startMid && k == 4) i_start = 1'b1;
            if (k == 6) begin
                checkOutput("holdRs", 64'(o_layer_RS), 64'(lastCommit.rs));
                checkOutput("holdRow", 64'(o_psum_row_id), 64'(lastCommit.row));
                checkOutput("holdCol", 64'(o_psum_col_id), 64'(lastCommit.col));
                checkOutput("holdValid", 64'(o_cfg_valid), 64'(lastValid));
                checkOutput("busyMidLoad", 64'(o_busy), 64'd1);
            end
            sendBeat(v.beats[(BEATS-1-k)*4 +: 4], v.bubbles && (k != BEATS - 1), ok);
            i_start = 1'b0;
            if (ok) accepted++;
        end
        i_cfg_valid = 1'b0;
        checkOutput("beatCount", 64'(accepted), 64'(BEATS));
        checkOutput("doneLatency", 64'(o_cfg_done), 64'd1);
        checkOutput("readyInCommit", 64'(o_cfg_ready), 64'd0);
        checkOutput("holdInCommit", 64'(o_psum_col_id), 64'(lastCommit.col));
        @(negedge i_clk);
    endtask

    // The scoreboard. The cycle after o_cfg_done is seen, the new outputs
    // must be visible and the pulse must be gone.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (armed) begin
            armed = 1'b0;
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedCommit", 64'd1, 64'd0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("commitRs", 64'(o_layer_RS), 64'(e.rs));
                checkOutput("commitRow", 64'(o_psum_row_id), 64'(e.row));
                checkOutput("commitCol", 64'(o_psum_col_id), 64'(e.col));
                checkOutput("commitValid", 64'(o_cfg_valid), 64'd1);
                checkOutput("donePulseWidth", 64'(o_cfg_done), 64'd0);
                checkOutput("busyAfterCommit", 64'(o_busy), 64'd0);
                checkOutput("narrowRow", 64'(b_psum_row_id), 64'(e.row2));
                checkOutput("narrowRs", 64'(b_layer_RS), 64'(e.rs));
                lastCommit = e;
                lastValid  = 1'b1;
            end
        end
        if (o_cfg_done) armed = 1'b1;
    end

    // Checks that every output of both instances is in its reset state.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Rs"}, 64'(o_layer_RS), 64'd0);
        checkOutput({tag, "Row"}, 64'(o_psum_row_id), 64'd0);
        checkOutput({tag, "Col"}, 64'(o_psum_col_id), 64'd0);
        checkOutput({tag, "Ready"}, 64'(o_cfg_ready), 64'd0);
        checkOutput({tag, "Busy"}, 64'(o_busy), 64'd0);
        checkOutput({tag, "Valid"}, 64'(o_cfg_valid), 64'd0);
        checkOutput({tag, "Done"}, 64'(o_cfg_done), 64'd0);
        checkOutput({tag, "NarrowRow"}, 64'(b_psum_row_id), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        bit ok;
        vecs[0] = '{beats:52'h3123012345678, bubbles:1'b0, startMid:1'b0, expRs:4'h3,
                    expRow:12'h123, expCol:36'h012345678, expRow2:6'h1B};
        vecs[1] = '{beats:52'h3123012345678, bubbles:1'b1, startMid:1'b0, expRs:4'h3,
                    expRow:12'h123, expCol:36'h012345678, expRow2:6'h1B};
        vecs[2] = '{beats:52'h1111FFFFFFFFF, bubbles:1'b0, startMid:1'b0, expRs:4'h1,
                    expRow:12'h111, expCol:36'hFFFFFFFFF, expRow2:6'h15};
        vecs[3] = '{beats:52'hFF74AAAAAAAAA, bubbles:1'b0, startMid:1'b1, expRs:4'hF,
                    expRow:12'hF74, expCol:36'hAAAAAAAAA, expRow2:6'h3C};
        vecs[4] = '{beats:52'h9C5E123456789, bubbles:1'b1, startMid:1'b0, expRs:4'h9,
                    expRow:12'hC5E, expCol:36'h123456789, expRow2:6'h06};
        lastCommit = '{rs:4'h0, row:12'h0, col:36'h0, row2:6'h0};
        lastValid  = 1'b0;

        i_rst_n = 1'b0; i_start = 1'b0; i_cfg_valid = 1'b0; i_cfg_data = 4'h0;
        repeat (3) @(negedge i_clk);
        checkAllZero("reset");
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        checkOutput("idleBusy", 64'(o_busy), 64'd0);

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        // Abort a load after five beats. The partial load must be discarded.
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < 5; k++) sendBeat(4'h7, 1'b0, ok);
        i_cfg_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        checkAllZero("midReset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        lastCommit = '{rs:4'h0, row:12'h0, col:36'h0, row2:6'h0};
        lastValid  = 1'b0;
        repeat (4) @(negedge i_clk);
        checkOutput("afterAbortValid", 64'(o_cfg_valid), 64'd0);
        checkOutput("afterAbortBusy", 64'(o_busy), 64'd0);

        applyStimulus(vecs[4]);

        repeat (5) @(negedge i_clk);
        checkOutput("scoreboardEmpty", 64'(sbQueue.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
